dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder that terminates the pipelined CPU's MEM-stage data port.
- Accepts a combinational address, write data, write strobe and access type from the EX/MEM register. Returns sign- or zero-extended read data in the same cycle, so the CPU captures it into MEM/WB at the next posedge.
- Contains word-organised RAM with byte-lane stores, a small MMIO register window (LEDs, cycle counter, store counter, error status), and sticky misaligned-store error tracking.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit RAM words; must be a power of 2.
- MMIO_BASE, 32'hFFFF0000, base of the MMIO window; the window is MMIO_BASE..MMIO_BASE+0x1F.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_w  in  1  store strobe for the current cycle
- addr  in  32  byte address (CPU ALU result)
- wdata  in  32  store data; unshifted, low bits significant
- dmtype  in  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
- rdata  out  32  extended load data, combinational from addr/dmtype
- led_out  out  16  LED register
- err_flag  out  1  sticky misaligned-store flag
- err_addr  out  32  address of the first misaligned store since the last clear
- dbg_sel  in  5  RAM word index for debug
- dbg_data  out  32  raw RAM word at dbg_sel (combinational)

Behaviour:
- Reset (synchronous, 1 cycle), clears: led_out=0, err_flag=0, err_addr=0, err_count=0, cycle_cnt=0, store_cnt=0. RAM contents are not cleared.
- Decode:
  - MMIO if addr[31:5]==MMIO_BASE[31:5].
  - RAM if addr[31:2+log2(DEPTH_WORDS)]==0.
  - Anything else is unmapped: reads return 0, stores are dropped and not counted.
- Alignment:
  - Word requires addr[1:0]==0.
  - Half requires addr[0]==0.
  - Byte is always aligned.
  - dmtype values 101–111 are treated as word.
- Store (posedge, mem_w=1, reset=0):
  - Aligned RAM store: word writes all 4 lanes. Half writes lanes {addr[1],0}/+1 with wdata[15:0]. Byte writes lane addr[1:0] with wdata[7:0]. Other lanes are preserved.
  - Misaligned store: no lanes written, err_count saturates at 255.
  - If err_flag was 0, err_addr<=addr and err_flag<=1. Later misaligned stores leave err_addr unchanged.
  - store_cnt (32-bit, wraps) increments on every accepted aligned RAM or MMIO store.
- Load (combinational):
  - Word: returns the full word.
  - Half: selects the lane pair by addr[1], then sign-extends (001) or zero-extends (010).
  - Byte: selects lane addr[1:0], then sign-extends (011) or zero-extends (100).
  - A misaligned load returns 0; no error is recorded, because the CPU drives addr every cycle.
- Read-after-write: a load of an address stored at edge N returns the new data in cycle N+1. In the store cycle itself, rdata shows the old contents.
- MMIO map (offsets from MMIO_BASE):
  - 0x00 LED: R/W. Low 16 bits hold value; lanes 2–3 read 0 and writes to them are ignored. Byte and half stores merge per lane.
  - 0x04 cycle_cnt[31:0]: RO.
  - 0x08 cycle_cnt[63:32]: RO.
  - 0x0C store_cnt: RO.
  - 0x10 status = {16'b0, err_count[7:0], 7'b0, err_flag}. Any aligned store with wdata[0]=1 clears err_flag, err_addr and err_count; that store is counted in store_cnt.
  - 0x14–0x1C: read 0, writes ignored.
  - Stores to RO registers are dropped but counted in store_cnt.
- cycle_cnt: 64-bit, increments every non-reset cycle and wraps. A read returns the pre-increment value of that cycle.
- Simultaneous events: reset has priority over any store. Only one access per cycle exists, so there are no port conflicts.

Optional Feature:
- Macro DMEM_MMIO_EN.
- Defined: MMIO window is decoded as above.
- Undefined: the MMIO window is treated as unmapped, with reads 0 and stores dropped. led_out is tied to 0 and no counters are built.
- err_flag, err_addr and the misalignment checks exist in both builds. Without the macro, err_flag/err_addr clear only on reset.

Test Plan:
- Store word 0x80F0_7F01 at 0x10, then load byte at 0x10/0x11/0x13 -> 0x00000001, 0x0000007F, 0xFFFFFF80. Load byte-unsigned at 0x13 -> 0x00000080.
- Preload 0x11223344 at 0x20, then store half 0xABCD at 0x22 -> word reads 0xABCD3344. Half at 0x22 -> 0xFFFFABCD; half-unsigned -> 0x0000ABCD.
- Store word at 0x06, then store half at 0x09 -> RAM unchanged, err_flag=1, err_addr=0x06, status read = 0x00000201. Then store 1 to MMIO+0x10 -> status 0.
- Store byte 0x5A to MMIO+0x01 -> led_out=0x5A00. Store word 0xFFFF1234 to MMIO+0x00 -> led_out=0x1234, LED word reads 0x00001234.
- Release reset, idle 10 cycles, then load MMIO+0x04 -> 10 and MMIO+0x0C -> 0. Do 3 stores, then load MMIO+0x0C -> 3.
- Store to 0x0001_0000 (unmapped) -> no RAM change, store_cnt unchanged, load returns 0. Assert reset mid-sequence -> all counters and led_out are 0 on the next cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data responder: byte-lane RAM, misaligned-store tracking, MMIO window.
// Optional MMIO window (LED, cycle/store counters, status) is built only when DMEM_MMIO_EN is defined.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 128,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_w,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  dmtype,
   output logic [31:0] rdata,
   output logic [15:0] led_out,
   output logic        err_flag,
   output logic [31:0] err_addr,
   input  logic [4:0]  dbg_sel,
   output logic [31:0] dbg_data
);
   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   ram [DEPTH_WORDS];
   logic          is_half, is_byte, is_signed, aligned, is_ram, is_mmio, status_clr;
   logic [AW-1:0] widx, dbg_idx;
   logic [3:0]    be;
   logic [31:0]   wlane, src, shifted, mmio_rd;

   assign is_ram  = (addr[31:2+AW] == '0);
   assign widx    = addr[2+AW-1:2];
   assign dbg_idx = AW'(dbg_sel);
   assign dbg_data = ram[dbg_idx];

   // Codes 101-111 fall through to word handling.
   always_comb begin
      is_half   = (dmtype == 3'b001) || (dmtype == 3'b010);
      is_byte   = (dmtype == 3'b011) || (dmtype == 3'b100);
      is_signed = (dmtype == 3'b001) || (dmtype == 3'b011);
      aligned   = is_byte || (is_half && !addr[0]) || (!is_half && !is_byte && addr[1:0] == 2'b00);
      be        = 4'b1111;
      wlane     = wdata;
      if (is_half) begin
         be    = addr[1] ? 4'b1100 : 4'b0011;
         wlane = {wdata[15:0], wdata[15:0]};
      end else if (is_byte) begin
         be    = 4'b0001 << addr[1:0];
         wlane = {4{wdata[7:0]}};
      end
   end

   always_comb begin
      src = 32'h0;
      if (is_ram)
         src = ram[widx];
      else if (is_mmio)
         src = mmio_rd;
      shifted = src >> {addr[1:0], 3'b000};
      rdata   = 32'h0;
      if (aligned) begin
         if (is_half)
            rdata = {{16{is_signed & shifted[15]}}, shifted[15:0]};
         else if (is_byte)
            rdata = {{24{is_signed & shifted[7]}}, shifted[7:0]};
         else
            rdata = src;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && mem_w && aligned && is_ram) begin
         for (int i = 0; i < 4; i++)
            if (be[i])
               ram[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
   end

   // Only the first misaligned store since the last clear is latched.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_flag <= 1'b0;
         err_addr <= 32'h0;
      end else if (mem_w && !aligned) begin
         if (!err_flag) begin
            err_flag <= 1'b1;
            err_addr <= addr;
         end
      end else if (status_clr) begin
         err_flag <= 1'b0;
         err_addr <= 32'h0;
      end
   end

`ifdef DMEM_MMIO_EN
   logic [63:0] cycle_cnt;
   logic [31:0] store_cnt;
   logic [7:0]  err_count;
   logic [15:0] led;
   logic        mmio_st;

   assign is_mmio    = (addr[31:5] == MMIO_BASE[31:5]);
   assign mmio_st    = mem_w && aligned && is_mmio;
   assign status_clr = mmio_st && (addr[4:2] == 3'd4) && wdata[0];
   assign led_out    = led;

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= 64'h0;
         store_cnt <= 32'h0;
         err_count <= 8'h0;
         led       <= 16'h0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (mem_w && aligned && (is_ram || is_mmio))
            store_cnt <= store_cnt + 32'd1;
         if (mmio_st && addr[4:2] == 3'd0) begin
            if (be[0]) led[7:0]  <= wlane[7:0];
            if (be[1]) led[15:8] <= wlane[15:8];
         end
         if (mem_w && !aligned) begin
            if (err_count != 8'hFF)
               err_count <= err_count + 8'd1;
         end else if (status_clr) begin
            err_count <= 8'h0;
         end
      end
   end

   always_comb begin
      case (addr[4:2])
         3'd0:    mmio_rd = {16'h0, led};
         3'd1:    mmio_rd = cycle_cnt[31:0];
         3'd2:    mmio_rd = cycle_cnt[63:32];
         3'd3:    mmio_rd = store_cnt;
         3'd4:    mmio_rd = {16'h0, err_count, 7'h0, err_flag};
         default: mmio_rd = 32'h0;
      endcase
   end
`else
   logic unused_ok;
   assign is_mmio    = 1'b0;
   assign status_clr = 1'b0;
   assign mmio_rd    = 32'h0;
   assign led_out    = 16'h0;
   assign unused_ok  = ^MMIO_BASE;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder.
module tb_dmem_responder;
`ifdef DMEM_MMIO_EN
   localparam bit MMIO = 1'b1;
`else
   localparam bit MMIO = 1'b0;
`endif
   localparam logic [31:0] MB = 32'hFFFF0000;

   logic        clk = 1'b0, reset = 1'b1, mem_w = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [2:0]  dmtype = 3'b000;
   logic [4:0]  dbg_sel = 5'd0;
   logic [31:0] rdata, err_addr, dbg_data;
   logic [15:0] led_out;
   logic        err_flag;
   int          total = 0, bad = 0;

   dmem_responder dut (
      .clk(clk), .reset(reset), .mem_w(mem_w), .addr(addr), .wdata(wdata), .dmtype(dmtype),
      .rdata(rdata), .led_out(led_out), .err_flag(err_flag), .err_addr(err_addr),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; mem_w = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
      @(negedge clk);
      mem_w = 1'b1; addr = a; wdata = d; dmtype = t;
      @(posedge clk);
      #1 mem_w = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [2:0] t, output logic [31:0] r);
      @(negedge clk);
      mem_w = 1'b0; addr = a; dmtype = t;
      #1 r = rdata;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h expected=%08h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      do_reset();
      total++;
      if (led_out !== 16'h0 || err_flag !== 1'b0 || err_addr !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs got led=%04h flag=%0b eaddr=%08h expected 0", led_out, err_flag, err_addr);
      end
      do_load(MB + 32'h0C, 3'b000, r);
      total++;
      if (r !== 32'h0) begin bad++; $display("FAIL reset_store_cnt got=%08h expected=00000000", r); end
   endtask

   task automatic test_byte_loads();
      logic [31:0] r;
      do_store(32'h10, 32'h80F07F01, 3'b000);
      do_load(32'h10, 3'b011, r);
      total++; if (r !== 32'h00000001) begin bad++; $display("FAIL lb_10 got=%08h expected=00000001", r); end
      do_load(32'h11, 3'b011, r);
      total++; if (r !== 32'h0000007F) begin bad++; $display("FAIL lb_11 got=%08h expected=0000007f", r); end
      do_load(32'h13, 3'b011, r);
      total++; if (r !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_13 got=%08h expected=ffffff80", r); end
      do_load(32'h13, 3'b100, r);
      total++; if (r !== 32'h00000080) begin bad++; $display("FAIL lbu_13 got=%08h expected=00000080", r); end
      do_load(32'h12, 3'b000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL lw_misaligned got=%08h expected=00000000", r); end
      dbg_sel = 5'd4;
      #1;
      total++; if (dbg_data !== 32'h80F07F01) begin bad++; $display("FAIL dbg_word4 got=%08h expected=80f07f01", dbg_data); end
   endtask

   task automatic test_half();
      logic [31:0] r;
      do_store(32'h20, 32'h11223344, 3'b000);
      do_store(32'h22, 32'h5555ABCD, 3'b001);
      do_load(32'h20, 3'b000, r);
      total++; if (r !== 32'hABCD3344) begin bad++; $display("FAIL half_merge got=%08h expected=abcd3344", r); end
      do_load(32'h22, 3'b001, r);
      total++; if (r !== 32'hFFFFABCD) begin bad++; $display("FAIL lh_22 got=%08h expected=ffffabcd", r); end
      do_load(32'h22, 3'b010, r);
      total++; if (r !== 32'h0000ABCD) begin bad++; $display("FAIL lhu_22 got=%08h expected=0000abcd", r); end
      do_load(32'h20, 3'b111, r);
      total++; if (r !== 32'hABCD3344) begin bad++; $display("FAIL type7_word got=%08h expected=abcd3344", r); end
   endtask

   task automatic test_raw();
      logic [31:0] r;
      do_store(32'h40, 32'h00000001, 3'b000);
      @(negedge clk);
      mem_w = 1'b1; addr = 32'h40; wdata = 32'h00000002; dmtype = 3'b000;
      #1 r = rdata;
      total++; if (r !== 32'h1) begin bad++; $display("FAIL raw_same_cycle got=%08h expected=00000001", r); end
      @(posedge clk);
      #1 mem_w = 1'b0;
      do_load(32'h40, 3'b000, r);
      total++; if (r !== 32'h2) begin bad++; $display("FAIL raw_next_cycle got=%08h expected=00000002", r); end
   endtask

   task automatic test_misaligned();
      logic [31:0] r;
      do_reset();
      do_store(32'h04, 32'hAAAA5555, 3'b000);
      do_store(32'h08, 32'h12345678, 3'b000);
      do_store(32'h06, 32'hDEADBEEF, 3'b000);
      do_store(32'h09, 32'h0000FFFF, 3'b001);
      do_load(32'h04, 3'b000, r);
      total++; if (r !== 32'hAAAA5555) begin bad++; $display("FAIL mis_ram04 got=%08h expected=aaaa5555", r); end
      do_load(32'h08, 3'b000, r);
      total++; if (r !== 32'h12345678) begin bad++; $display("FAIL mis_ram08 got=%08h expected=12345678", r); end
      total++; if (err_flag !== 1'b1) begin bad++; $display("FAIL err_flag_set got=%0b expected=1", err_flag); end
      total++; if (err_addr !== 32'h06) begin bad++; $display("FAIL err_addr got=%08h expected=00000006", err_addr); end
      do_load(MB + 32'h10, 3'b000, r);
      total++; if (r !== (MMIO ? 32'h00000201 : 32'h0)) begin
         bad++; $display("FAIL status_read got=%08h expected=%08h", r, MMIO ? 32'h00000201 : 32'h0); end
      do_store(MB + 32'h10, 32'h1, 3'b000);
      do_load(MB + 32'h10, 3'b000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL status_clear got=%08h expected=00000000", r); end
      total++; if (err_flag !== !MMIO) begin bad++; $display("FAIL err_flag_after_clear got=%0b expected=%0b", err_flag, !MMIO); end
   endtask

   task automatic test_led();
      logic [31:0] r;
      do_store(MB + 32'h01, 32'h0000005A, 3'b011);
      total++; if (led_out !== (MMIO ? 16'h5A00 : 16'h0)) begin
         bad++; $display("FAIL led_byte got=%04h expected=%04h", led_out, MMIO ? 16'h5A00 : 16'h0); end
      do_store(MB, 32'hFFFF1234, 3'b000);
      total++; if (led_out !== (MMIO ? 16'h1234 : 16'h0)) begin
         bad++; $display("FAIL led_word got=%04h expected=%04h", led_out, MMIO ? 16'h1234 : 16'h0); end
      do_load(MB, 3'b000, r);
      total++; if (r !== (MMIO ? 32'h00001234 : 32'h0)) begin
         bad++; $display("FAIL led_read got=%08h expected=%08h", r, MMIO ? 32'h00001234 : 32'h0); end
   endtask

   task automatic test_counters();
      logic [31:0] r;
      do_reset();
      repeat (10) @(posedge clk);
      do_load(MB + 32'h04, 3'b000, r);
      total++; if (r !== (MMIO ? 32'd10 : 32'h0)) begin
         bad++; $display("FAIL cycle_cnt got=%08h expected=%08h", r, MMIO ? 32'd10 : 32'h0); end
      do_load(MB + 32'h0C, 3'b000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL store_cnt_idle got=%08h expected=00000000", r); end
      do_store(32'h60, 32'h1, 3'b000);
      do_store(32'h64, 32'h2, 3'b011);
      do_store(MB + 32'h04, 32'h3, 3'b000);
      do_load(MB + 32'h0C, 3'b000, r);
      total++; if (r !== (MMIO ? 32'd3 : 32'h0)) begin
         bad++; $display("FAIL store_cnt_3 got=%08h expected=%08h", r, MMIO ? 32'd3 : 32'h0); end
   endtask

   task automatic test_unmapped_and_reset();
      logic [31:0] r;
      do_store(32'h0, 32'hCAFEF00D, 3'b000);
      do_store(32'h00010000, 32'h11111111, 3'b000);
      do_load(32'h0, 3'b000, r);
      total++; if (r !== 32'hCAFEF00D) begin bad++; $display("FAIL unmapped_alias got=%08h expected=cafef00d", r); end
      do_load(32'h00010000, 3'b000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%08h expected=00000000", r); end
      do_load(MB + 32'h0C, 3'b000, r);
      total++; if (r !== (MMIO ? 32'd4 : 32'h0)) begin
         bad++; $display("FAIL unmapped_store_cnt got=%08h expected=%08h", r, MMIO ? 32'd4 : 32'h0); end
      do_store(MB, 32'h0000BEEF, 3'b000);
      do_store(32'h07, 32'h0, 3'b001);
      do_reset();
      total++; if (led_out !== 16'h0 || err_flag !== 1'b0 || err_addr !== 32'h0) begin
         bad++; $display("FAIL mid_reset got led=%04h flag=%0b eaddr=%08h expected 0", led_out, err_flag, err_addr); end
      do_load(MB + 32'h0C, 3'b000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_reset_store_cnt got=%08h expected=00000000", r); end
      do_load(MB + 32'h08, 3'b000, r);
      total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_reset_cycle_hi got=%08h expected=00000000", r); end
      do_load(32'h0, 3'b000, r);
      total++; if (r !== 32'hCAFEF00D) begin bad++; $display("FAIL ram_kept got=%08h expected=cafef00d", r); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      test_reset();
      test_byte_loads();
      test_half();
      test_raw();
      test_misaligned();
      test_led();
      test_counters();
      test_unmapped_and_reset();
      chk("final_led_idle", {16'h0, led_out}, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
